// File: rtl/quat_sad_best_if.sv
// Handshake/result bundle between the quarter-pel interpolator, quat_sad_best
// and the mode-decision logic.
//   start     : begin a new block (honoured only when busy=0)
//   in_valid  : cur_pix/quat carry a valid pixel position this cycle
//   cur_pix   : co-located current-block pixel
//   quat      : 9 quarter-pel candidates, raster order, index 4 = centre
//   busy      : block in progress (accumulating or comparing)
//   out_valid : one-cycle pulse, best_idx/best_sad valid
//   best_idx  : winning candidate index 0..8
//   best_sad  : SAD of the winning candidate
interface quat_sad_best_if #(
    parameter int SAD_W = 12
);
    logic             start;
    logic             in_valid;
    logic [7:0]       cur_pix;
    logic [8:0][7:0]  quat;
    logic             busy;
    logic             out_valid;
    logic [3:0]       best_idx;
    logic [SAD_W-1:0] best_sad;

    modport master (
        output start, in_valid, cur_pix, quat,
        input  busy, out_valid, best_idx, best_sad
    );

    modport slave (
        input  start, in_valid, cur_pix, quat,
        output busy, out_valid, best_idx, best_sad
    );
endinterface

// File: rtl/quat_sad_best.sv
// Quarter-pel SAD accumulation and best-candidate selection.
// Accumulates nine SADs (one per quarter-pel candidate) over BLK_PIX pixel
// positions, then walks the candidates one per cycle to pick the minimum,
// with the centre candidate winning all ties.
// Ports:
//   clk : clock, all logic on the rising edge
//   rst : synchronous active-high reset
//   bus : quat_sad_best_if slave (start/in_valid/cur_pix/quat in,
//         busy/out_valid/best_idx/best_sad out)
//
// state | meaning
// IDLE  | waiting for start
// ACCUM | adding |quat[k]-cur_pix| into the nine accumulators
// CMP   | 8 cycles, one candidate compared per cycle against the running best
// DONE  | one cycle, out_valid=1; start here chains straight into ACCUM
module quat_sad_best #(
    parameter int BLK_PIX = 16,
    parameter int SAD_W   = 12
) (
    input  logic            clk,
    input  logic            rst,
    quat_sad_best_if.slave  bus
);

    localparam int              CNT_W    = (BLK_PIX > 1) ? $clog2(BLK_PIX) : 1;
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(BLK_PIX - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, CMP, DONE} state_t;

    state_t           state;
    state_t           state_next;

    logic [SAD_W-1:0] acc      [9];
    logic [SAD_W-1:0] acc_next [9];
    logic [8:0]       diff     [9];
    logic [SAD_W:0]   sum      [9];

    logic [CNT_W-1:0] pix_cnt;
    logic [2:0]       cmp_cnt;

    logic [3:0]       run_idx;
    logic [SAD_W-1:0] run_sad;
    logic [3:0]       best_idx_q;
    logic [SAD_W-1:0] best_sad_q;

    logic [3:0]       cand_idx;
    logic [3:0]       seed_idx;
    logic [SAD_W-1:0] seed_sad;
    logic [3:0]       win_idx;
    logic [SAD_W-1:0] win_sad;

    logic             busy;
    logic             out_valid;
    logic             blk_start;
    logic             accept;

    // Absolute difference and saturating accumulate for all nine candidates.
    always_comb begin
        for (int k = 0; k < 9; k++) begin
            if (bus.quat[k] >= bus.cur_pix)
                diff[k] = {1'b0, bus.quat[k] - bus.cur_pix};
            else
                diff[k] = {1'b0, bus.cur_pix - bus.quat[k]};
            sum[k]      = {1'b0, acc[k]} + (SAD_W+1)'(diff[k]);
            acc_next[k] = sum[k][SAD_W] ? '1 : sum[k][SAD_W-1:0];
        end
    end

    // Compare order skips the centre: cmp_cnt 0..3 -> 0..3, 4..7 -> 5..8.
    // The centre seeds the running best in the first compare cycle, so with a
    // strict less-than it keeps every tie; ascending order makes the lowest
    // index win among non-centre ties.
    always_comb begin
        cand_idx = (cmp_cnt < 3'd4) ? {1'b0, cmp_cnt} : {1'b0, cmp_cnt} + 4'd1;
        if (cmp_cnt == 3'd0) begin
            seed_idx = 4'd4;
            seed_sad = acc[4];
        end else begin
            seed_idx = run_idx;
            seed_sad = run_sad;
        end
        if (acc[cand_idx] < seed_sad) begin
            win_idx = cand_idx;
            win_sad = acc[cand_idx];
        end else begin
            win_idx = seed_idx;
            win_sad = seed_sad;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start)
                    state_next = ACCUM;
            end
            ACCUM: begin
                busy = 1'b1;
                if (bus.in_valid && (pix_cnt == LAST_PIX))
                    state_next = CMP;
            end
            CMP: begin
                busy = 1'b1;
                if (cmp_cnt == 3'd7)
                    state_next = DONE;
            end
            DONE: begin
                out_valid  = 1'b1;
                state_next = bus.start ? ACCUM : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign blk_start = bus.start && ((state == IDLE) || (state == DONE));
    assign accept    = (state == ACCUM) && bus.in_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 9; k++)
                acc[k] <= '0;
            pix_cnt    <= '0;
            cmp_cnt    <= '0;
            run_idx    <= 4'd4;
            run_sad    <= '0;
            best_idx_q <= 4'd4;
            best_sad_q <= '0;
        end else begin
            if (blk_start) begin
                for (int k = 0; k < 9; k++)
                    acc[k] <= '0;
                pix_cnt <= '0;
            end else if (accept) begin
                for (int k = 0; k < 9; k++)
                    acc[k] <= acc_next[k];
                pix_cnt <= (pix_cnt == LAST_PIX) ? '0 : pix_cnt + CNT_W'(1);
            end

            if (state == CMP) begin
                run_idx <= win_idx;
                run_sad <= win_sad;
                cmp_cnt <= cmp_cnt + 3'd1;
                // Result registers load on the last compare, i.e. at DONE entry.
                if (cmp_cnt == 3'd7) begin
                    best_idx_q <= win_idx;
                    best_sad_q <= win_sad;
                end
            end else begin
                cmp_cnt <= '0;
            end
        end
    end

    assign bus.busy      = busy;
    assign bus.out_valid = out_valid;
    assign bus.best_idx  = best_idx_q;
    assign bus.best_sad  = best_sad_q;

endmodule

// File: tb/tb_quat_sad_best.sv
module tb_quat_sad_best;

    localparam int BLK_PIX = 16;
    localparam int SAD_W   = 12;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    quat_sad_best_if #(.SAD_W(SAD_W)) bus ();

    quat_sad_best #(.BLK_PIX(BLK_PIX), .SAD_W(SAD_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0]      blk_cur [BLK_PIX];
    logic [8:0][7:0] blk_q   [BLK_PIX];

    typedef struct {
        string           name;
        logic [7:0]      cur;
        logic [8:0][7:0] q;
        int              stall;
        bit              chain;
        int              e_idx;
        int              e_sad;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: SAD is the plain sum of absolute differences; the winner is
    // the centre if it attains the minimum, else the lowest index attaining it.
    task automatic model(output int idx, output int sad);
        int s[9];
        int m;
        for (int k = 0; k < 9; k++) begin
            s[k] = 0;
            for (int i = 0; i < BLK_PIX; i++) begin
                int d;
                d = int'(blk_q[i][k]) - int'(blk_cur[i]);
                s[k] += (d < 0) ? -d : d;
            end
            if (s[k] > (1 << SAD_W) - 1) s[k] = (1 << SAD_W) - 1;
        end
        m = s[0];
        for (int k = 1; k < 9; k++)
            if (s[k] < m) m = s[k];
        sad = m;
        idx = -1;
        if (s[4] == m) begin
            idx = 4;
        end else begin
            for (int k = 8; k >= 0; k--)
                if (s[k] == m) idx = k;
        end
    endtask

    task automatic rand_block(input int mode);
        int base;
        base = $urandom_range(0, 250);
        for (int i = 0; i < BLK_PIX; i++) begin
            if (mode == 0) begin
                blk_cur[i] = 8'($urandom);
                blk_q[i]   = 72'({$urandom, $urandom, $urandom});
            end else begin
                blk_cur[i] = 8'(base + $urandom_range(0, 2));
                for (int k = 0; k < 9; k++)
                    blk_q[i][k] = 8'(base + $urandom_range(0, 2));
            end
        end
    endtask

    // stall: 0 none, 1 strict 1/0 toggle, 2 random gaps 0..3.
    // Stall and CMP cycles also carry junk data and random start pulses.
    task automatic run_block(input string name, input int stall, input bit chain,
                             input int e_idx, input int e_sad);
        int lat;
        int ns;
        lat = 0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk({name, "_busy_accum"}, int'(bus.busy), 1);
        for (int i = 0; i < BLK_PIX; i++) begin
            ns = (stall == 1) ? ((i > 0) ? 1 : 0) : (stall == 2) ? $urandom_range(0, 3) : 0;
            for (int j = 0; j < ns; j++) begin
                bus.in_valid = 1'b0;
                bus.cur_pix  = 8'($urandom);
                bus.quat     = 72'({$urandom, $urandom, $urandom});
                bus.start    = 1'($urandom_range(0, 1));
                tick();
                bus.start    = 1'b0;
            end
            bus.in_valid = 1'b1;
            bus.cur_pix  = blk_cur[i];
            bus.quat     = blk_q[i];
            if (i < BLK_PIX - 1) tick();
        end
        for (int n = 1; n <= 20; n++) begin
            tick();
            bus.in_valid = 1'b0;
            bus.start    = 1'b0;
            if (bus.out_valid) begin
                lat = n;
                break;
            end
            if (stall != 0) begin
                chk({name, "_busy_cmp"}, int'(bus.busy), 1);
                bus.start = 1'($urandom_range(0, 1));
            end
        end
        chk({name, "_latency"}, lat, 9);
        chk({name, "_best_idx"}, int'(bus.best_idx), e_idx);
        chk({name, "_best_sad"}, int'(bus.best_sad), e_sad);
        chk({name, "_busy_done"}, int'(bus.busy), 0);
        if (!chain) begin
            tick();
            chk({name, "_pulse_len"}, int'(bus.out_valid), 0);
            chk({name, "_hold_idx"}, int'(bus.best_idx), e_idx);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int e_idx, e_sad, seen;

        vecs[0] = '{"all_equal",  8'd100, {9{8'd100}}, 0, 1'b0, 4, 0};
        vecs[1] = '{"distinct",   8'd100,
                    {8'd118, 8'd115, 8'd112, 8'd109, 8'd106, 8'd103, 8'd100, 8'd103, 8'd106},
                    0, 1'b0, 2, 0};
        vecs[2] = '{"tie_noncentre", 8'd100,
                    {8'd102, 8'd99, 8'd102, 8'd102, 8'd102, 8'd102, 8'd102, 8'd101, 8'd102},
                    0, 1'b0, 1, 16};
        vecs[3] = '{"tie_centre", 8'd100,
                    {8'd102, 8'd99, 8'd102, 8'd102, 8'd101, 8'd102, 8'd102, 8'd101, 8'd102},
                    0, 1'b0, 4, 16};
        vecs[4] = '{"stall_distinct", 8'd100,
                    {8'd118, 8'd115, 8'd112, 8'd109, 8'd106, 8'd103, 8'd100, 8'd103, 8'd106},
                    1, 1'b0, 2, 0};
        vecs[5] = '{"max_mag",    8'd0,   {9{8'd255}}, 0, 1'b1, 4, 4080};
        vecs[6] = '{"min_idx8",   8'd50,  {8'd55, {8{8'd60}}}, 0, 1'b1, 8, 80};
        vecs[7] = '{"min_idx0",   8'd200, {{8{8'd190}}, 8'd200}, 2, 1'b0, 0, 0};

        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.cur_pix  = '0;
        bus.quat     = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_out_valid", int'(bus.out_valid), 0);
        chk("reset_best_idx", int'(bus.best_idx), 4);
        chk("reset_best_sad", int'(bus.best_sad), 0);

        // in_valid while idle must not start anything
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.cur_pix  = 8'($urandom);
            bus.quat     = 72'({$urandom, $urandom, $urandom});
            tick();
            chk("idle_ignores_in_valid", int'(bus.busy), 0);
        end
        bus.in_valid = 1'b0;

        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < BLK_PIX; i++) begin
                blk_cur[i] = vecs[v].cur;
                blk_q[i]   = vecs[v].q;
            end
            run_block(vecs[v].name, vecs[v].stall, vecs[v].chain, vecs[v].e_idx, vecs[v].e_sad);
        end

        // Reset after 7 samples: partial block discarded, no result pulse.
        rand_block(0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus.in_valid = 1'b1;
            bus.cur_pix  = blk_cur[i];
            bus.quat     = blk_q[i];
            tick();
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", int'(bus.busy), 0);
        chk("midrst_best_idx", int'(bus.best_idx), 4);
        chk("midrst_best_sad", int'(bus.best_sad), 0);
        seen = 0;
        for (int n = 0; n < 20; n++) begin
            if (bus.out_valid) seen++;
            tick();
        end
        chk("midrst_no_pulse", seen, 0);
        rand_block(0);
        model(e_idx, e_sad);
        run_block("after_rst", 0, 1'b0, e_idx, e_sad);

        // Randomised blocks: full-range data and narrow-range data (tie-rich),
        // random stalls and random back-to-back chaining.
        for (int b = 0; b < 30; b++) begin
            bit ch;
            rand_block($urandom_range(0, 1));
            model(e_idx, e_sad);
            ch = (b < 29) ? 1'($urandom_range(0, 1)) : 1'b0;
            run_block($sformatf("rand%0d", b), ($urandom_range(0, 1) != 0) ? 2 : 0, ch, e_idx, e_sad);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/quat_sad_best.md
Name: quat_sad_best

Overview:
- Sits directly downstream of the quarter-pel interpolator in the FME path.
- Consumes the 9 quarter-pel candidate samples around the best half-pel position, one pixel position per cycle. Each cycle also supplies the co-located current-block pixel.
- Accumulates one SAD per candidate over a block, then sequentially selects the minimum.
- Reports the winning quarter-pel index (0..8, 4 = centre) and its SAD to the mode-decision/MV-refinement logic.

Parameters:
- BLK_PIX, 16, number of pixel positions per block (4x4 default).
- SAD_W, 12, accumulator/result width; must be >= 8 + clog2(BLK_PIX).

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a new block; accepted only when busy=0.
- in_valid  input  1  cur_pix/quat valid this cycle.
- cur_pix  input  8  current-block pixel.
- quat  input  9x8 (packed [8:0][7:0])  quarter-pel candidate samples, index 0..8 in raster order, 4 = centre.
- busy  output  1  high in ACCUM and CMP.
- out_valid  output  1  one-cycle pulse: result valid.
- best_idx  output  4  winning candidate index.
- best_sad  output  SAD_W  SAD of winning candidate.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state=IDLE, all 9 accumulators=0, pixel counter=0, busy=0, out_valid=0, best_idx=4, best_sad=0.
- Reset has priority over every other input in any state, including mid-ACCUM and mid-CMP. The partial result is discarded; no out_valid is produced.
- FSM states: IDLE, ACCUM, CMP, DONE.
- IDLE:
  - start=1: clear accumulators and counter, go to ACCUM.
  - in_valid is ignored.
- ACCUM:
  - When in_valid=1: acc[k] += |quat[k] - cur_pix| for k=0..8, using 9-bit unsigned difference magnitude; counter++.
  - When in_valid=0: hold (stall), any duration.
  - When in_valid=1 with counter = BLK_PIX-1: perform the final add, go to CMP.
  - start is ignored.
- Arithmetic: accumulators saturate at 2^SAD_W-1. With legal SAD_W, saturation is unreachable (255*BLK_PIX fits).
- CMP: exactly 8 cycles.
  - First cycle: the running best is seeded with (acc[4], idx 4).
  - Candidates are compared in order 0,1,2,3,5,6,7,8, one per cycle.
  - The running best is replaced only if acc[k] < best_sad (strict).
  - Tie-break: centre wins all ties. Among non-centre ties, the lowest index wins.
  - After the 8th compare, go to DONE.
- DONE: one cycle.
  - out_valid=1; busy=0.
  - best_idx/best_sad are updated at DONE entry and held until the next DONE.
  - start=1 in DONE is accepted and goes directly to ACCUM; otherwise go to IDLE.
- Latency: if the final sample is accepted in cycle T, out_valid=1 in cycle T+9.
- Throughput: one block per BLK_PIX + 9 cycles minimum.
- best_idx values 9..15 are never produced.

Test Plan:
- All-equal: cur_pix=100, all quat[k]=100 for 16 samples, in_valid held high -> out_valid exactly 9 cycles after the last sample; best_idx=4, best_sad=0.
- Distinct minimum: cur_pix=100, quat[k]=100+3*|k-2| -> best_idx=2, best_sad=0. Candidate 4 would have SAD 96; it loses.
- Tie-break:
  - quat[1] and quat[7] differ from cur by 1; all others, including centre, differ by 2 -> best_idx=1, best_sad=16.
  - Repeat with centre also differing by 1 -> best_idx=4, best_sad=16.
- Stall: repeat the distinct-minimum stimulus with in_valid toggling 1/0 -> identical result, out_valid 9 cycles after the 16th accepted sample. start pulses during ACCUM and CMP are ignored (busy=1, no restart).
- Max magnitude: cur_pix=0, all quat=255 -> all SAD 4080 (0xFF0, no saturation); best_idx=4, best_sad=4080.
- Reset and back-to-back:
  - Assert rst after 7 samples of a block -> busy=0, out_valid never pulses, best_idx=4, best_sad=0. A fresh block then yields a result from the new data only.
  - Assert start in the DONE cycle -> next block accepted with no idle cycle; its out_valid follows 9 cycles after its last sample.
